// File: rtl/robot_pkg.sv
// Shared definitions for the robot navigation blocks.
//   state_e  : wall-follower controller states
//   ROT_CW / ROT_CCW : encoding of the rotation direction output
package robot_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        FOLLOW = 2'd1,
        REACQ  = 2'd2,
        STUCK  = 2'd3
    } state_e;

    localparam logic ROT_CW  = 1'b0;
    localparam logic ROT_CCW = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, reusable by any robot block that counts events.
//   clk   : rising-edge clock
//   reset : synchronous, active-high clear
//   inc   : count one event this cycle
//   count : current count, sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wall_follower.sv
// Wall-following navigation controller with stuck detection.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   en                : run enable; low freezes state/counters and gates moves
//   head, left, right : obstacle ahead / wall left / wall right
//   resume            : one-cycle request to leave STUCK (works even with en=0)
//   front, rotate     : Mealy movement commands, never both high
//   rot_dir           : 0 = clockwise, 1 = counter-clockwise (valid with rotate)
//   stuck             : high while in STUCK
//   moves             : saturating count of front cycles
module wall_follower
    import robot_pkg::*;
#(
    parameter int SIDE    = 0,
    parameter int MAX_ROT = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             head,
    input  logic             left,
    input  logic             right,
    input  logic             resume,
    output logic             front,
    output logic             rotate,
    output logic             rot_dir,
    output logic             stuck,
    output logic [CNT_W-1:0] moves
);

    localparam int             RW       = $clog2(MAX_ROT + 1);
    localparam logic [RW-1:0]  LAST_ROT = RW'(MAX_ROT - 1);
    // "away" turns the followed wall behind us; "toward" turns back onto it
    localparam logic           AWAY     = (SIDE == 0) ? ROT_CW : ROT_CCW;
    localparam logic           TOWARD   = ~AWAY;

    state_e        state_q, state_d;
    logic [RW-1:0] rot_cnt_q, rot_cnt_d;
    logic          ws;

    assign ws = (SIDE == 0) ? left : right;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEARCH;
            rot_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rot_cnt_q <= rot_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rot_cnt_d = rot_cnt_q;
        front     = 1'b0;
        rotate    = 1'b0;
        rot_dir   = AWAY;

        if (state_q == STUCK) begin
            // resume bypasses en so a disabled robot can still be re-armed
            if (resume) begin
                state_d   = SEARCH;
                rot_cnt_d = '0;
            end
        end else if (en) begin
            case (state_q)
                SEARCH: begin
                    if (head) begin
                        rotate  = 1'b1;
                        state_d = FOLLOW;
                    end else begin
                        front = 1'b1;
                        if (ws) state_d = FOLLOW;
                    end
                end
                FOLLOW: begin
                    if (head) begin
                        rotate = 1'b1;
                    end else if (ws) begin
                        front = 1'b1;
                    end else begin
                        rotate  = 1'b1;
                        rot_dir = TOWARD;
                        state_d = REACQ;
                    end
                end
                REACQ: begin
                    state_d = FOLLOW;
                    if (head) rotate = 1'b1;
                    else      front  = 1'b1;
                end
                default: ;
            endcase

            if (front) begin
                rot_cnt_d = '0;
            end
            if (rotate) begin
                rot_cnt_d = rot_cnt_q + RW'(1);
                // the last permitted rotation is still issued, then we give up
                if (rot_cnt_q == LAST_ROT) state_d = STUCK;
            end
        end
    end

    assign stuck = (state_q == STUCK);

    sat_counter #(.W(CNT_W)) u_moves (
        .clk   (clk),
        .reset (reset),
        .inc   (front),
        .count (moves)
    );

endmodule

// File: tb/tb_wall_follower.sv
module tb_wall_follower;

    logic clk, reset, en, head, left, right, resume;
    logic [2:0] fr, ro, rd, st;
    logic [7:0] mv_a, mv_b;
    logic [2:0] mv_c;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    idx;
        logic  f, r, d, s;
        int    mv;
    } exp_t;

    exp_t sb[$];

    // A: left wall, CNT_W=8; B: right wall; C: left wall, 3-bit move counter
    wall_follower #(.SIDE(0), .MAX_ROT(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .head(head), .left(left), .right(right),
        .resume(resume), .front(fr[0]), .rotate(ro[0]), .rot_dir(rd[0]),
        .stuck(st[0]), .moves(mv_a));
    wall_follower #(.SIDE(1), .MAX_ROT(4), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .head(head), .left(left), .right(right),
        .resume(resume), .front(fr[1]), .rotate(ro[1]), .rot_dir(rd[1]),
        .stuck(st[1]), .moves(mv_b));
    wall_follower #(.SIDE(0), .MAX_ROT(4), .CNT_W(3)) dut_c (
        .clk(clk), .reset(reset), .en(en), .head(head), .left(left), .right(right),
        .resume(resume), .front(fr[2]), .rotate(ro[2]), .rot_dir(rd[2]),
        .stuck(st[2]), .moves(mv_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int moves_of(input int idx);
        if (idx == 0) return int'(mv_a);
        if (idx == 1) return int'(mv_b);
        return int'(mv_c);
    endfunction

    task automatic check_one();
        exp_t e;
        logic [3:0] obs_b, exp_b;
        int obs_m;
        e = sb.pop_front();
        obs_b = {fr[e.idx], ro[e.idx], st[e.idx], 1'b0};
        exp_b = {e.f, e.r, e.s, 1'b0};
        obs_m = moves_of(e.idx);
        checks++;
        assert (obs_b === exp_b) else begin
            errors++;
            $error("FAIL %s outputs{front,rotate,stuck}: got %b want %b", e.tag, obs_b[3:1], exp_b[3:1]);
        end
        checks++;
        assert (obs_m === e.mv) else begin
            errors++;
            $error("FAIL %s moves: got %0d want %0d", e.tag, obs_m, e.mv);
        end
        if (e.r) begin
            checks++;
            assert (rd[e.idx] === e.d) else begin
                errors++;
                $error("FAIL %s rot_dir: got %b want %b", e.tag, rd[e.idx], e.d);
            end
        end
    endtask

    task automatic step(input int idx, input logic e_i, h, l, r, rs, rst,
                        input logic ef, er, ed, es, input int em, input string tag);
        @(negedge clk);
        en = e_i; head = h; left = l; right = r; resume = rs; reset = rst;
        sb.push_back('{tag, idx, ef, er, ed, es, em});
        #1;
        check_one();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; head = 1'b0; left = 1'b0; right = 1'b0; resume = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; head = 1'b0; left = 1'b0; right = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clk);

        // forward run in SEARCH
        do_reset();
        for (int k = 0; k < 5; k++)
            step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, k, "fwd");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, "fwd_freeze");
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, "fwd_still_search");

        // wall follow sequence
        do_reset();
        step(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, "wf_front1");
        step(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, "wf_rot_away");
        step(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, "wf_front2");
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, "wf_rot_toward");
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, "wf_reacq_front");

        // stuck, resume with en=0, stuck again, resume with en=1
        do_reset();
        for (int k = 0; k < 4; k++)
            step(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "st_rot");
        step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, "st_stuck");
        step(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, "st_resume_en0");
        for (int k = 0; k < 4; k++)
            step(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, "st_rot2");
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, "st_resume_en1");
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "st_back_search");

        // mirror: right wall
        do_reset();
        step(1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, "mir_away");
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "mir_toward");

        // saturation and freeze on 3-bit counter
        do_reset();
        for (int k = 0; k < 10; k++)
            step(2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, (k > 7) ? 7 : k, "sat_front");
        step(2, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 7, "sat_to_follow");
        for (int k = 0; k < 3; k++)
            step(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, "frz");
        step(2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7, "frz_still_follow");

        // reset while in REACQ, then while in STUCK
        do_reset();
        step(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, "rr_front");
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, "rr_to_reacq");
        step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, "rr_reset_reacq");
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rr_after_reset1");
        for (int k = 0; k < 4; k++)
            step(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, "rr_rot");
        step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, "rr_stuck");
        step(0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, "rr_reset_stuck");
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rr_after_reset2");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wall_follower.md
WALL_FOLLOWER -- requirements
Module: wall_follower

Interface
REQ-001 Parameter SIDE, default 0, selects the followed wall: 0 = left, 1 = right.
REQ-002 Parameter MAX_ROT, default 4, sets how many consecutive rotate cycles are allowed before STUCK; legal range 2..15.
REQ-003 Parameter CNT_W, default 8, sets the width of the forward-move counter.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high. Clock port is clk; reset port is reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  1 = run; 0 = freeze state and counters, and force movement outputs low.
REQ-008 head  input  1  obstacle directly ahead.
REQ-009 left  input  1  wall present on the left.
REQ-010 right  input  1  wall present on the right.
REQ-011 resume  input  1  single-cycle request to leave STUCK.
REQ-012 front  output  1  advance one step this cycle.
REQ-013 rotate  output  1  rotate 90 degrees this cycle.
REQ-014 rot_dir  output  1  rotation direction: 0 = clockwise, 1 = counter-clockwise; meaningful only when rotate=1.
REQ-015 stuck  output  1  high while in STUCK.
REQ-016 moves  output  CNT_W  saturating count of front cycles.

Function
REQ-017 Define ws = left when SIDE=0 and ws = right when SIDE=1. Define "away" = clockwise for SIDE=0 and counter-clockwise for SIDE=1; "toward" is the opposite direction.
REQ-018 Mealy outputs: front, rotate and rot_dir SHALL be combinational in (state, en, head, ws). State and counters update on the rising edge of clk.
REQ-019 front and rotate SHALL never both be 1; when en=0, front=rotate=0.
REQ-020 SEARCH state:
- head=1: rotate away, go to FOLLOW.
- head=0, ws=1: front, go to FOLLOW.
- head=0, ws=0: front, stay in SEARCH.
REQ-021 FOLLOW state:
- head=1: rotate away, stay in FOLLOW.
- head=0, ws=1: front, stay in FOLLOW.
- head=0, ws=0: rotate toward, go to REACQ.
REQ-022 REACQ state:
- head=0: front, go to FOLLOW.
- head=1: rotate away, go to FOLLOW.
REQ-023 Rotation counter rot_cnt:
- increments on every rotate cycle;
- clears on every front cycle;
- holds when en=0.
REQ-024 A rotate cycle with rot_cnt = MAX_ROT-1 SHALL still issue the rotate. The next state is then STUCK, overriding any transition in REQ-020 to REQ-022.
REQ-025 STUCK state:
- front=0, rotate=0, stuck=1.
- resume=1 moves to SEARCH and clears rot_cnt; this is honoured even when en=0.
- resume outside STUCK is ignored.
REQ-026 moves SHALL increment by 1 on each front cycle and saturate at 2^CNT_W-1 (no wrap-around).
REQ-027 stuck SHALL be a decode of state==STUCK; it has no extra latency.

Reset
REQ-028 When reset=1 at a clk edge, the block SHALL go to SEARCH with rot_cnt=0 and moves=0, so stuck=0 in the following cycle. Reset overrides en and resume, including mid-rotation and while in STUCK.
REQ-029 During the reset cycle, the Mealy outputs SHALL still reflect the pre-reset state and inputs. No output is gated by reset.

Structure
REQ-030 Shared package robot_pkg SHALL hold:
- the state typedef (SEARCH, FOLLOW, REACQ, STUCK);
- the ROT_CW=0 and ROT_CCW=1 constants.
REQ-031 The move counter SHALL be a sub-module sat_counter (parameter W; ports clk, reset, inc, count). It is reusable by other robot blocks.
REQ-032 rot_cnt width SHALL be $clog2(MAX_ROT+1). The next-state/output logic SHALL be a single combinational process.

Verification
REQ-033 Forward run: SIDE=0, reset, then head=0 left=0 for 5 cycles -> front=1 every cycle, state stays SEARCH, moves=5.
REQ-034 Wall follow: SIDE=0 from SEARCH, inputs (0,1) (1,1) (0,1) (0,0) (0,0) -> outputs in order:
- front;
- rotate rot_dir=0;
- front;
- rotate rot_dir=1 (enters REACQ);
- front (returns to FOLLOW).
REQ-035 Stuck: SIDE=0, MAX_ROT=4, head=1 left=1 for 4 cycles -> 4 rotates, then stuck=1 and front=rotate=0. Next, resume=1 for 1 cycle -> SEARCH, stuck=0.
REQ-036 Mirror: SIDE=1 with right=1 and left=0, head=1 -> rotate with rot_dir=1; right=0 in FOLLOW -> rotate with rot_dir=0.
REQ-037 Saturation and freeze:
- CNT_W=3: 10 front cycles -> moves=7.
- en=0 for 3 cycles mid-run -> front=rotate=0, and moves and state unchanged.
REQ-038 Reset mid-operation: reset=1 while in REACQ, and again while in STUCK -> next cycle is SEARCH with moves=0 and stuck=0.
